// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the register file
package regfile_pkg;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  // Address width with a floor of one bit, so tiny depths still get a real port
  function automatic int addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_cell.sv
// rtl/reg_cell.sv - one storage word with load enable and async active-low reset
module reg_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 1W/2R register file with write-first bypass and bulk clear
module register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int ZERO_REG0 = 1,
  localparam int ADDR_W   = addr_width(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_enable,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]  w_data,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [WIDTH-1:0]  ra_data,
  output logic [WIDTH-1:0]  rb_data,
  input  logic              clear_start,
  output logic              busy
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  clr_state_t        state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [WIDTH-1:0]  words [DEPTH];
  logic              user_we, eff_we;
  logic [ADDR_W-1:0] eff_addr;
  logic [WIDTH-1:0]  eff_data;
  logic [WIDTH-1:0]  ra_next, rb_next;

  assign busy = (state == CLEAR);

  // The clear engine owns the write port while busy; user writes are dropped
  always_comb begin
    user_we  = w_enable && !busy && ({1'b0, w_addr} < DEPTH_EXT)
               && !((ZERO_REG0 != 0) && (w_addr == '0));
    eff_we   = busy || user_we;
    eff_addr = busy ? idx : w_addr;
    eff_data = busy ? '0 : w_data;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    if ((ZERO_REG0 != 0) && (g == 0)) begin : g_zero
      assign words[g] = '0;
    end else begin : g_cell
      reg_cell #(.WIDTH(WIDTH)) u_cell (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (eff_we && (eff_addr == ADDR_W'(g))),
        .d       (eff_data),
        .q       (words[g])
      );
    end
  end

  // Out-of-range addresses fall through to zero
  function automatic logic [WIDTH-1:0] read_word(input logic [ADDR_W-1:0] a);
    read_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == ADDR_W'(i)) read_word = words[i];
    end
  endfunction

  always_comb begin
    ra_next = (eff_we && (eff_addr == ra_addr)) ? eff_data : read_word(ra_addr);
    rb_next = (eff_we && (eff_addr == rb_addr)) ? eff_data : read_word(rb_addr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ra_data <= '0;
      rb_data <= '0;
    end else begin
      ra_data <= ra_next;
      rb_data <= rb_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_next = CLEAR;
          idx_next   = '0;
        end
      end
      CLEAR: begin
        if (idx == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file
module tb_register_file;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        w_enable, clear_start;
  logic [2:0]  w_addr, ra_addr, rb_addr;
  logic [15:0] w_data;
  logic [15:0] ra_z, rb_z, ra_n, rb_n;
  logic        busy_z, busy_n;

  logic        w6_en, cs6;
  logic [2:0]  w6_addr, ra6_addr, rb6_addr;
  logic [31:0] w6_data, ra6_data, rb6_data;
  logic        busy6;

  register_file #(.WIDTH(16), .DEPTH(8), .ZERO_REG0(1)) dut (
    .clock(clock), .reset_n(reset_n), .w_enable(w_enable), .w_addr(w_addr),
    .w_data(w_data), .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_z),
    .rb_data(rb_z), .clear_start(clear_start), .busy(busy_z));

  register_file #(.WIDTH(16), .DEPTH(8), .ZERO_REG0(0)) dut_nz (
    .clock(clock), .reset_n(reset_n), .w_enable(w_enable), .w_addr(w_addr),
    .w_data(w_data), .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_n),
    .rb_data(rb_n), .clear_start(clear_start), .busy(busy_n));

  register_file #(.WIDTH(32), .DEPTH(6), .ZERO_REG0(1)) dut6 (
    .clock(clock), .reset_n(reset_n), .w_enable(w6_en), .w_addr(w6_addr),
    .w_data(w6_data), .ra_addr(ra6_addr), .rb_addr(rb6_addr), .ra_data(ra6_data),
    .rb_data(rb6_data), .clear_start(cs6), .busy(busy6));

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] exp_ra;
    logic [15:0] exp_rb;
    logic [15:0] exp_ra_n;
  } vec_t;

  vec_t tbl[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb, input logic cs);
    w_enable = we; w_addr = wa; w_data = wd;
    ra_addr = ra; rb_addr = rb; clear_start = cs;
  endtask

  task automatic drive6(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic cs);
    w6_en = we; w6_addr = wa; w6_data = wd;
    ra6_addr = ra; rb6_addr = rb; cs6 = cs;
  endtask

  task automatic do_reset;
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
    drive6(1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 1'b0);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Reference state: contents of each 8-entry variant plus the clear progress
  logic [15:0] mem_z [8];
  logic [15:0] mem_n [8];
  logic        clr_active;
  int          clr_pos;

  initial begin
    int n_busy;
    reset_n = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
    drive6(1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy_z}, 32'd0);
    chk("reset_ra", {16'd0, ra_z}, 32'd0);
    chk("reset_rb", {16'd0, rb_z}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 3'd0, 16'h0, 3'(a), 3'(7 - a), 1'b0);
      tick();
      chk($sformatf("reset_read_a%0d", a), {16'd0, ra_z}, 32'd0);
      chk($sformatf("reset_read_b%0d", 7 - a), {16'd0, rb_z}, 32'd0);
    end

    tbl[0] = '{1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    tbl[2] = '{1'b1, 3'd5, 16'h1234, 3'd3, 3'd5, 16'hBEEF, 16'h1234, 16'hBEEF};
    tbl[3] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd5, 16'h0000, 16'h1234, 16'hFFFF};
    tbl[4] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, 16'h0000, 16'hBEEF, 16'hFFFF};
    tbl[5] = '{1'b1, 3'd7, 16'hA5A5, 3'd7, 3'd7, 16'hA5A5, 16'hA5A5, 16'hA5A5};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, 1'b0);
      tick();
      chk($sformatf("vec%0d_ra", i), {16'd0, ra_z}, {16'd0, tbl[i].exp_ra});
      chk($sformatf("vec%0d_rb", i), {16'd0, rb_z}, {16'd0, tbl[i].exp_rb});
      chk($sformatf("vec%0d_ra_nz", i), {16'd0, ra_n}, {16'd0, tbl[i].exp_ra_n});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy_z}, 32'd0);
    end

    // Bulk clear: fill, start with a coincident write, hammer writes and restarts while busy
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 3'(a), 16'h1000 + 16'(a), 3'd0, 3'd0, 1'b0);
      tick();
    end
    drive(1'b1, 3'd2, 16'h7777, 3'd2, 3'd4, 1'b1);
    tick();
    chk("clr_start_write_bypass", {16'd0, ra_z}, 32'h7777);
    chk("clr_start_rb", {16'd0, rb_z}, 32'h1004);
    n_busy = 0;
    while (busy_z && n_busy < 50) begin
      n_busy++;
      drive(1'b1, 3'd1, 16'hDEAD, 3'd6, 3'd1, n_busy == 3);
      tick();
    end
    chk("clr_busy_cycles", n_busy, 8);
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 3'd0, 16'h0, 3'(a), 3'(a), 1'b0);
      tick();
      chk($sformatf("clr_after_a%0d", a), {16'd0, ra_z}, 32'd0);
      chk($sformatf("clr_after_b%0d", a), {16'd0, rb_z}, 32'd0);
    end
    chk("clr_after_busy", {31'd0, busy_z}, 32'd0);

    // Asynchronous reset in the middle of a clear
    drive(1'b1, 3'd5, 16'h5555, 3'd0, 3'd0, 1'b0); tick();
    drive(1'b1, 3'd6, 16'h6666, 3'd0, 3'd0, 1'b0); tick();
    drive(1'b1, 3'd7, 16'h7777, 3'd0, 3'd0, 1'b0); tick();
    drive(1'b0, 3'd0, 16'h0, 3'd7, 3'd6, 1'b1); tick();
    drive(1'b0, 3'd0, 16'h0, 3'd7, 3'd6, 1'b0);
    tick(); tick(); tick();
    chk("midclr_busy_before", {31'd0, busy_z}, 32'd1);
    chk("midclr_ra_before", {16'd0, ra_z}, 32'h7777);
    #2 reset_n = 1'b0;
    #1;
    chk("midclr_busy_async", {31'd0, busy_z}, 32'd0);
    chk("midclr_ra_async", {16'd0, ra_z}, 32'd0);
    chk("midclr_rb_async", {16'd0, rb_z}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int a = 5; a < 8; a++) begin
      drive(1'b0, 3'd0, 16'h0, 3'(a), 3'(a), 1'b0);
      tick();
      chk($sformatf("midclr_entry%0d", a), {16'd0, ra_z}, 32'd0);
    end
    chk("midclr_busy_after", {31'd0, busy_z}, 32'd0);

    // Non-power-of-two depth
    drive6(1'b1, 3'd6, 32'hCAFEF00D, 3'd7, 3'd6, 1'b0); tick();
    chk("d6_read7", ra6_data, 32'd0);
    chk("d6_write6_no_bypass", rb6_data, 32'd0);
    drive6(1'b1, 3'd5, 32'h12345678, 3'd6, 3'd5, 1'b0); tick();
    chk("d6_read6", ra6_data, 32'd0);
    chk("d6_bypass5", rb6_data, 32'h12345678);
    drive6(1'b1, 3'd7, 32'hFFFFFFFF, 3'd5, 3'd7, 1'b0); tick();
    chk("d6_read5", ra6_data, 32'h12345678);
    chk("d6_write7_dropped", rb6_data, 32'd0);
    drive6(1'b0, 3'd0, 32'h0, 3'd5, 3'd5, 1'b1); tick();
    drive6(1'b0, 3'd0, 32'h0, 3'd5, 3'd5, 1'b0);
    n_busy = 0;
    while (busy6 && n_busy < 50) begin
      n_busy++;
      tick();
    end
    chk("d6_busy_cycles", n_busy, 6);
    tick();
    chk("d6_clr_entry5", ra6_data, 32'd0);

    // Randomized traffic against the reference arrays
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem_z[i] = '0;
      mem_n[i] = '0;
    end
    clr_active = 1'b0;
    clr_pos    = 0;
    for (int n = 0; n < 400; n++) begin
      logic        we, cs;
      logic [2:0]  wa, ra, rb;
      logic [15:0] wd;
      we = 1'($urandom_range(0, 1));
      cs = ($urandom_range(0, 24) == 0);
      wa = 3'($urandom_range(0, 7));
      ra = 3'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      drive(we, wa, wd, ra, rb, cs);
      if (clr_active) begin
        mem_z[clr_pos] = '0;
        mem_n[clr_pos] = '0;
        clr_pos++;
        if (clr_pos == 8) clr_active = 1'b0;
      end else begin
        if (we) begin
          mem_n[wa] = wd;
          if (wa != 3'd0) mem_z[wa] = wd;
        end
        if (cs) begin
          clr_active = 1'b1;
          clr_pos    = 0;
        end
      end
      tick();
      chk($sformatf("rnd%0d_ra", n), {16'd0, ra_z}, {16'd0, mem_z[ra]});
      chk($sformatf("rnd%0d_rb", n), {16'd0, rb_z}, {16'd0, mem_z[rb]});
      chk($sformatf("rnd%0d_ra_nz", n), {16'd0, ra_n}, {16'd0, mem_n[ra]});
      chk($sformatf("rnd%0d_rb_nz", n), {16'd0, rb_n}, {16'd0, mem_n[rb]});
      chk($sformatf("rnd%0d_busy", n), {31'd0, busy_z}, {31'd0, clr_active});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
